// File: rtl/kbd_key_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jk_kbd_pkg
// Brief   : Scancode constants and parser state encoding for kbd_key_decoder
// Rev     : 1.0  initial release
// ============================================================================
package jk_kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXT       = 2'd1,
    BREAK     = 2'd2,
    EXT_BREAK = 2'd3
  } kbd_state_t;

endpackage
`default_nettype wire

// File: rtl/kbd_key_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : kbd_key_decoder_if
// Brief   : Scancode byte input and key/jump outputs of the keyboard decoder
// Rev     : 1.0  initial release
// ============================================================================
interface kbd_key_decoder_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       key_space;
  logic       key_left;
  logic       key_right;
  logic       jump_valid;
  logic [7:0] jump_power;

  modport slave (
    input  rx_data, rx_valid,
    output key_space, key_left, key_right, jump_valid, jump_power
  );

  modport master (
    output rx_data, rx_valid,
    input  key_space, key_left, key_right, jump_valid, jump_power
  );

endinterface
`default_nettype wire

// File: rtl/kbd_key_decoder_ms_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : ms_tick_gen
// Brief   : Enabled prescaler with synchronous clear; tick on the wrap cycle
// Rev     : 1.0  initial release
// ============================================================================
module ms_tick_gen #(
  parameter int CLOCKS_PER_MS = 40_000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  output logic      tick
);

  localparam int c_W = (CLOCKS_PER_MS > 1) ? $clog2(CLOCKS_PER_MS) : 1;
  localparam logic [c_W-1:0] c_LAST = c_W'(CLOCKS_PER_MS - 1);

  logic [c_W-1:0] r_cnt;

  assign tick = en && !clr && (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kbd_key_decoder.sv
`default_nettype none
// ============================================================================
// Module  : kbd_key_decoder
// Brief   : PS/2 make/break tracking for Space/Left/Right plus Space hold timer
// Rev     : 1.0  initial release
// ============================================================================
module kbd_key_decoder
  import jk_kbd_pkg::*;
#(
  parameter int CLK_HZ         = 40_000_000,
  parameter int MAX_CHARGE_MS  = 255,
  parameter int PREFIX_TIMEOUT = 100_000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  kbd_key_decoder_if.slave   bus
);

  localparam int c_CLOCKS_PER_MS = CLK_HZ / 1000;
  localparam int c_TO_W          = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(PREFIX_TIMEOUT - 1);
  localparam logic [7:0]        c_MAX_CHG  = 8'(MAX_CHARGE_MS);

  kbd_state_t r_state, w_state_nxt;

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_space_held, r_left_held, r_right_held;
  logic              w_space_make, w_space_break;
  logic              w_left_make, w_left_break;
  logic              w_right_make, w_right_break;
  logic              w_tick;
  logic [7:0]        r_charge_ms;
  logic [7:0]        r_charge_cap;
  logic              r_jump_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // E0 resyncs from any state; F0 while already in a break state is absorbed
  always_comb begin
    w_state_nxt   = r_state;
    w_space_make  = 1'b0;
    w_space_break = 1'b0;
    w_left_make   = 1'b0;
    w_left_break  = 1'b0;
    w_right_make  = 1'b0;
    w_right_break = 1'b0;
    if (bus.rx_valid) begin
      unique case (r_state)
        IDLE: begin
          if (bus.rx_data == SC_BREAK)      w_state_nxt = BREAK;
          else if (bus.rx_data == SC_EXT)   w_state_nxt = EXT;
          else if (bus.rx_data == SC_SPACE) w_space_make = !r_space_held;
        end
        EXT: begin
          w_state_nxt = IDLE;
          if (bus.rx_data == SC_BREAK)      w_state_nxt = EXT_BREAK;
          else if (bus.rx_data == SC_EXT)   w_state_nxt = EXT;
          else if (bus.rx_data == SC_LEFT)  w_left_make  = 1'b1;
          else if (bus.rx_data == SC_RIGHT) w_right_make = 1'b1;
        end
        BREAK: begin
          w_state_nxt = IDLE;
          if (bus.rx_data == SC_BREAK)      w_state_nxt = BREAK;
          else if (bus.rx_data == SC_EXT)   w_state_nxt = EXT;
          else if (bus.rx_data == SC_SPACE) w_space_break = r_space_held;
        end
        EXT_BREAK: begin
          w_state_nxt = IDLE;
          if (bus.rx_data == SC_BREAK)      w_state_nxt = EXT_BREAK;
          else if (bus.rx_data == SC_EXT)   w_state_nxt = EXT;
          else if (bus.rx_data == SC_LEFT)  w_left_break  = 1'b1;
          else if (bus.rx_data == SC_RIGHT) w_right_break = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE && r_to_cnt == c_TO_LAST) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.rx_valid || r_state == IDLE) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != c_TO_LAST) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_space_held <= 1'b0;
      r_left_held  <= 1'b0;
      r_right_held <= 1'b0;
    end else begin
      if (w_space_make)       r_space_held <= 1'b1;
      else if (w_space_break) r_space_held <= 1'b0;
      if (w_left_make)        r_left_held  <= 1'b1;
      else if (w_left_break)  r_left_held  <= 1'b0;
      if (w_right_make)       r_right_held <= 1'b1;
      else if (w_right_break) r_right_held <= 1'b0;
    end
  end

  ms_tick_gen #(
    .CLOCKS_PER_MS (c_CLOCKS_PER_MS)
  ) u_ms_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_space_make),
    .en   (r_space_held),
    .tick (w_tick)
  );

  // Break takes priority over a coincident ms tick, so the capture is pre-increment
  always_ff @(posedge clk) begin
    if (rst) begin
      r_charge_ms    <= '0;
      r_charge_cap   <= '0;
      r_jump_pending <= 1'b0;
    end else begin
      r_jump_pending <= w_space_break;
      if (w_space_break) begin
        r_charge_cap <= r_charge_ms;
        r_charge_ms  <= '0;
      end else if (w_space_make) begin
        r_charge_ms <= '0;
      end else if (w_tick && r_charge_ms < c_MAX_CHG) begin
        r_charge_ms <= r_charge_ms + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.key_space  <= 1'b0;
      bus.key_left   <= 1'b0;
      bus.key_right  <= 1'b0;
      bus.jump_valid <= 1'b0;
      bus.jump_power <= '0;
    end else begin
      bus.key_space  <= r_space_held;
      bus.key_left   <= r_left_held & ~r_right_held;
      bus.key_right  <= r_right_held & ~r_left_held;
      bus.jump_valid <= r_jump_pending;
      if (r_jump_pending) bus.jump_power <= r_charge_cap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kbd_key_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_kbd_key_decoder
// Brief   : Directed self-checking bench for kbd_key_decoder (4 clk/ms, timeout 16)
// Rev     : 1.0  initial release
// ============================================================================
module tb_kbd_key_decoder;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulse_cnt = 0;

  kbd_key_decoder_if bus ();

  kbd_key_decoder #(
    .CLK_HZ         (4000),
    .MAX_CHARGE_MS  (10),
    .PREFIX_TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.jump_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.key_space, bus.key_left, bus.key_right, bus.jump_valid, bus.jump_power} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: actual=%h required=000",
               {bus.key_space, bus.key_left, bus.key_right, bus.jump_valid, bus.jump_power});
    end
  endtask

  task automatic test_space_saturate();
    do_reset();
    send_byte(8'h29);
    n_cmp++;
    if (bus.key_space !== 1'b0) begin n_bad++; $display("FAIL space_latency: actual=%b required=0", bus.key_space); end
    idle(1);
    n_cmp++;
    if (bus.key_space !== 1'b1) begin n_bad++; $display("FAIL space_make: actual=%b required=1", bus.key_space); end
    idle(59);
    send_byte(8'hF0);
    send_byte(8'h29);
    n_cmp++;
    if (bus.key_space !== 1'b1 || bus.jump_valid !== 1'b0) begin
      n_bad++; $display("FAIL space_break_edge: actual space=%b jv=%b required space=1 jv=0", bus.key_space, bus.jump_valid);
    end
    idle(1);
    n_cmp++;
    if (bus.jump_valid !== 1'b1 || bus.jump_power !== 8'd10 || bus.key_space !== 1'b0) begin
      n_bad++; $display("FAIL jump_saturate: actual jv=%b pw=%0d space=%b required jv=1 pw=10 space=0",
                        bus.jump_valid, bus.jump_power, bus.key_space);
    end
    idle(1);
    n_cmp++;
    if (bus.jump_valid !== 1'b0 || bus.jump_power !== 8'd10) begin
      n_bad++; $display("FAIL jump_one_cycle: actual jv=%b pw=%0d required jv=0 pw=10", bus.jump_valid, bus.jump_power);
    end
  endtask

  task automatic test_direction();
    do_reset();
    send_byte(8'hE0); send_byte(8'h6B); idle(1);
    n_cmp++;
    if ({bus.key_left, bus.key_right} !== 2'b10) begin
      n_bad++; $display("FAIL left_make: actual L/R=%b required=10", {bus.key_left, bus.key_right});
    end
    send_byte(8'hE0); send_byte(8'h74); idle(1);
    n_cmp++;
    if ({bus.key_left, bus.key_right} !== 2'b00) begin
      n_bad++; $display("FAIL both_neutral: actual L/R=%b required=00", {bus.key_left, bus.key_right});
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B); idle(1);
    n_cmp++;
    if ({bus.key_left, bus.key_right, bus.key_space} !== 3'b010) begin
      n_bad++; $display("FAIL left_break: actual L/R/S=%b required=010", {bus.key_left, bus.key_right, bus.key_space});
    end
  endtask

  task automatic test_typematic_charge();
    int p0;
    do_reset();
    p0 = pulse_cnt;
    send_byte(8'h29); idle(2);
    send_byte(8'h29); idle(2);
    send_byte(8'h29); idle(3);
    send_byte(8'hF0); send_byte(8'h29); idle(1);
    n_cmp++;
    if (bus.jump_valid !== 1'b1 || bus.jump_power !== 8'd2) begin
      n_bad++; $display("FAIL typematic_charge: actual jv=%b pw=%0d required jv=1 pw=2", bus.jump_valid, bus.jump_power);
    end
    idle(2);
    n_cmp++;
    if (pulse_cnt - p0 !== 1) begin
      n_bad++; $display("FAIL typematic_pulses: actual=%0d required=1", pulse_cnt - p0);
    end
  endtask

  task automatic test_prefix_timeout();
    do_reset();
    send_byte(8'hE0); idle(20); send_byte(8'h6B); idle(2);
    n_cmp++;
    if ({bus.key_space, bus.key_left, bus.key_right} !== 3'b000) begin
      n_bad++; $display("FAIL timeout_ignored: actual S/L/R=%b required=000", {bus.key_space, bus.key_left, bus.key_right});
    end
    send_byte(8'h29); idle(1);
    n_cmp++;
    if (bus.key_space !== 1'b1) begin n_bad++; $display("FAIL timeout_recover: actual=%b required=1", bus.key_space); end
    do_reset();
    send_byte(8'hE0); idle(14); send_byte(8'h6B); idle(1);
    n_cmp++;
    if (bus.key_left !== 1'b1) begin n_bad++; $display("FAIL before_timeout: actual=%b required=1", bus.key_left); end
  endtask

  task automatic test_orphan_break();
    int p0;
    do_reset();
    p0 = pulse_cnt;
    send_byte(8'hF0); send_byte(8'h29); idle(3);
    n_cmp++;
    if ({bus.key_space, bus.key_left, bus.key_right, bus.jump_valid, bus.jump_power} !== 12'h000 || pulse_cnt != p0) begin
      n_bad++; $display("FAIL orphan_break: actual outs=%h pulses=%0d required outs=000 pulses=0",
                        {bus.key_space, bus.key_left, bus.key_right, bus.jump_valid, bus.jump_power}, pulse_cnt - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset();
    send_byte(8'h29); send_byte(8'hE0); send_byte(8'h6B); idle(2);
    n_cmp++;
    if ({bus.key_space, bus.key_left} !== 2'b11) begin
      n_bad++; $display("FAIL mid_setup: actual S/L=%b required=11", {bus.key_space, bus.key_left});
    end
    p0 = pulse_cnt;
    rst = 1'b1; idle(1); rst = 1'b0;
    n_cmp++;
    if ({bus.key_space, bus.key_left, bus.key_right, bus.jump_valid} !== 4'b0000) begin
      n_bad++; $display("FAIL mid_reset: actual S/L/R/J=%b required=0000",
                        {bus.key_space, bus.key_left, bus.key_right, bus.jump_valid});
    end
    send_byte(8'hF0); send_byte(8'h29); idle(3);
    n_cmp++;
    if (pulse_cnt != p0 || bus.key_space !== 1'b0) begin
      n_bad++; $display("FAIL mid_no_pulse: actual pulses=%0d space=%b required pulses=0 space=0", pulse_cnt - p0, bus.key_space);
    end
    send_byte(8'hE0);
    rst = 1'b1; idle(1); rst = 1'b0;
    send_byte(8'h6B); idle(2);
    n_cmp++;
    if (bus.key_left !== 1'b0) begin n_bad++; $display("FAIL prefix_discard: actual=%b required=0", bus.key_left); end
  endtask

  initial begin
    rst          = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    test_reset();
    test_space_saturate();
    test_direction();
    test_typematic_charge();
    test_prefix_timeout();
    test_orphan_break();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
